// File: rtl/sync_pipe_pkg.sv
// Shared definitions for the synchronous register pipeline: flow-control modes and occupancy sizing.
package sync_pipe_pkg;

  localparam int unsigned PIPE_LOCKSTEP = 0;
  localparam int unsigned PIPE_ELASTIC  = 1;

  // Bits needed to count 0..depth valid stages.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid+data register pair with synchronous reset, flush and load enable.
module pipe_stage
  import sync_pipe_pkg::*;
#(
  parameter int unsigned         WIDTH     = 8,
  parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Data only captures real words so bubbles never toggle the register.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = src_valid;
      if (src_valid) begin
        data_d = src_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/sync_reg_pipeline.sv
// DEPTH-stage retiming pipeline with valid/ready flow control, flush and occupancy count.
module sync_reg_pipeline
  import sync_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      ELASTIC   = PIPE_ELASTIC,
  localparam int unsigned     OCC_W     = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  logic [DEPTH-1:0] stg_valid;
  logic [WIDTH-1:0] stg_data [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic             in_xfer;
  logic             out_xfer;
  logic [OCC_W-1:0] occ_q, occ_d;

  if (DEPTH == 0) begin : g_bad_depth
    $error("sync_reg_pipeline: DEPTH must be at least 1");
  end

  // Ready ripples from the output back to the input; a stage is free if empty or its successor moves.
  always_comb begin
    rdy = '0;
    if (ELASTIC == PIPE_LOCKSTEP) begin
      rdy = {DEPTH{out_ready}};
    end else begin
      rdy[DEPTH-1] = !stg_valid[DEPTH-1] | out_ready;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        rdy[DEPTH-1-i] = !stg_valid[DEPTH-1-i] | rdy[DEPTH-i];
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             src_v;
    logic [WIDTH-1:0] src_d;

    if (g == 0) begin : g_head
      assign src_v = in_valid;
      assign src_d = in_data;
    end else begin : g_link
      assign src_v = stg_valid[g-1];
      assign src_d = stg_data[g-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .load      (rdy[g]),
      .src_valid (src_v),
      .src_data  (src_d),
      .valid     (stg_valid[g]),
      .data      (stg_data[g])
    );
  end

  assign in_ready  = rdy[0] & !flush;
  assign out_valid = stg_valid[DEPTH-1];
  assign out_data  = stg_data[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Counter tracks the number of valid stages; flush empties every stage at once.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_sync_reg_pipeline.sv
// Directed bench for sync_reg_pipeline: an elastic instance and a lockstep instance share stimulus.
module tb_sync_reg_pipeline;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       e_in_ready, e_out_valid;
  logic [7:0] e_out_data;
  logic [2:0] e_occ;
  logic       l_in_ready, l_out_valid;
  logic [7:0] l_out_data;
  logic [2:0] l_occ;

  bit         sel_dut;
  logic       t_in_ready, t_out_valid;
  logic [7:0] t_out_data;
  logic [2:0] t_occ;

  int checks   = 0;
  int failures = 0;

  sync_reg_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5), .ELASTIC(1)) dut_e (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(e_in_ready), .in_data(in_data),
    .out_valid(e_out_valid), .out_ready(out_ready), .out_data(e_out_data),
    .occupancy(e_occ)
  );

  sync_reg_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h3C), .ELASTIC(0)) dut_l (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(l_in_ready), .in_data(in_data),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_data(l_out_data),
    .occupancy(l_occ)
  );

  assign t_in_ready  = sel_dut ? l_in_ready  : e_in_ready;
  assign t_out_valid = sel_dut ? l_out_valid : e_out_valid;
  assign t_out_data  = sel_dut ? l_out_data  : e_out_data;
  assign t_occ       = sel_dut ? l_occ       : e_occ;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_e_out_valid", e_out_valid, 0);
    check("rst_e_occ", e_occ, 0);
    check("rst_e_out_data", e_out_data, 8'hA5);
    check("rst_e_in_ready", e_in_ready, 1);
    check("rst_l_out_valid", l_out_valid, 0);
    check("rst_l_out_data", l_out_data, 8'h3C);
  endtask

  // mode 0: out_ready=1; mode 1: out_ready toggles 1,0,...; mode 2: out_ready=0 for 8 cycles then 1.
  task automatic run_traffic(input bit sel, input int n, input logic [7:0] base,
                             input int mode, input int max_cyc);
    logic [7:0] q[$];
    int         sent = 0;
    int         recv = 0;
    int         first_acc = -1;
    int         first_ov = -1;
    bit         stall = 1'b0;
    logic [7:0] held = 8'h00;
    sel_dut = sel;
    for (int c = 0; c < max_cyc && recv < n; c++) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (c % 2 == 0);
        default: out_ready = (c >= 8);
      endcase
      in_valid = (sent < n);
      in_data  = base + 8'(sent);
      flush    = 1'b0;
      #1;
      check("occ_model", t_occ, q.size());
      if (sel) check("lock_in_ready", t_in_ready, out_ready);
      else if (mode == 0) check("stream_in_ready", t_in_ready, 1);
      if (stall) begin
        check("hold_valid", t_out_valid, 1);
        check("hold_data", t_out_data, held);
      end
      if (mode == 2 && c == 6) begin
        check("bp_accepts", sent, 4);
        check("bp_in_ready", t_in_ready, 0);
        check("bp_out_data", t_out_data, base);
      end
      if (t_out_valid && first_ov < 0) first_ov = c;
      if (t_out_valid && out_ready) begin
        if (q.size() == 0) check("spurious_out", 1, 0);
        else check("data_order", t_out_data, q.pop_front());
        recv++;
      end
      stall = t_out_valid && !out_ready;
      held  = t_out_data;
      if (in_valid && t_in_ready) begin
        if (first_acc < 0) first_acc = c;
        q.push_back(in_data);
        sent++;
      end
      tick();
    end
    check("drain_count", recv, n);
    if (mode == 0 && !sel) check("latency", first_ov - first_acc, 4);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel_dut   = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic       fl;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       exp_ov;
    logic [7:0] exp_od;
    logic       exp_ir;
    logic [2:0] exp_occ;
  } vec_t;

  vec_t vecs[10];

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    sel_dut = 1'b0;

    // Single word through the elastic pipe, then flush with an in-flight word.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 3'd0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'hA5, 1'b1, 3'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 3'd1};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 3'd1};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 3'd1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11, 1'b1, 3'd1};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 8'h11, 1'b1, 3'd1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 1'b1, 3'd1};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 8'h11, 1'b0, 3'd1};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 1'b1, 3'd0};

    tick();
    for (int k = 0; k < 10; k++) begin
      reset = vecs[k].rst; flush = vecs[k].fl; in_valid = vecs[k].iv;
      in_data = vecs[k].id; out_ready = vecs[k].ordy;
      #1;
      check($sformatf("vec%0d_out_valid", k), e_out_valid, vecs[k].exp_ov);
      check($sformatf("vec%0d_out_data", k), e_out_data, vecs[k].exp_od);
      check($sformatf("vec%0d_in_ready", k), e_in_ready, vecs[k].exp_ir);
      check($sformatf("vec%0d_occ", k), e_occ, vecs[k].exp_occ);
      tick();
    end

    do_reset();
    run_traffic(1'b0, 16, 8'h01, 0, 40);

    do_reset();
    run_traffic(1'b0, 6, 8'hA0, 2, 40);

    do_reset();
    run_traffic(1'b1, 8, 8'h40, 1, 60);

    // Flush with three words held and an offered input.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 8'hC0 + 8'(k);
      tick();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hC3;
    #1;
    check("flush_occ_before", e_occ, 3);
    check("flush_in_ready", e_in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_out_valid", e_out_valid, 0);
    check("flush_occ", e_occ, 0);
    check("flush_in_ready_after", e_in_ready, 1);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("flush_no_ghost", e_out_valid, 0);

    // Reset while the pipe is full and the sink is ready.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 8'hD0 + 8'(k);
      tick();
    end
    #1;
    check("full_occ", e_occ, 4);
    check("full_in_ready", e_in_ready, 0);
    check("full_out_data", e_out_data, 8'hD0);
    reset = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("midrst_out_valid", e_out_valid, 0);
    check("midrst_out_data", e_out_data, 8'hA5);
    check("midrst_occ", e_occ, 0);
    run_traffic(1'b0, 3, 8'hE0, 0, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
